jtkunio_sndcmd: RTL

Sound-command mailbox between the Kunio main 6502 and the sound CPU. It captures each main-CPU write to the sound-latch address and queues it in a small FIFO. It presents the oldest entry to the sound CPU and holds the sound-CPU IRQ asserted while commands are pending. It sits directly downstream of the main CPU's sound strobe/latch outputs and upstream of the sound CPU data bus and IRQ pin.

---
 rtl/jtkunio_sndcmd.sv | 138 +++++++++++++
 1 files changed

// File: rtl/jtkunio_sndcmd.sv
// jtkunio_sndcmd: sound-command mailbox from the Kunio main 6502 to the sound CPU.
// Each main-CPU write to the sound latch is captured once per access. The
// command is held until the sound CPU finishes reading it.
// Build option: JTKUNIO_SNDFIFO_EN selects a FIFO of depth 2**AW.
// Without it the block is a single-entry latch that matches the original board.
// snd_irq is held high while a command is pending. It drops for one clk after
// every pop, so edge-triggered CPUs see one edge per command.
module jtkunio_sndcmd #(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_wr,
  input  logic [7:0] main_din,
  input  logic       snd_rd,
  output logic [7:0] snd_dout,
  output logic       snd_irq,
  output logic       empty,
  output logic       full,
`ifdef JTKUNIO_SNDFIFO_EN
  output logic [AW:0] level,
`else
  output logic [0:0]  level,
`endif
  output logic       ovf,
  input  logic       ovf_clr
);

  logic wr_l;      // registered main_wr, for rising-edge detection
  logic rd_l;      // registered snd_rd, for falling-edge detection
  logic pop_d;     // an accepted pop happened last cycle
  logic push_edge;
  logic pop_edge;
  logic pop;       // pop that actually removes an entry
  logic ovf_set;

  // Push fires at the start of a write access. Pop fires at the end of a read
  // access, so snd_dout stays stable for the whole read.
  assign push_edge = main_wr & ~wr_l;
  assign pop_edge  = rd_l & ~snd_rd;

  // Strobe history, cleared by reset so a strobe held through reset counts once
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    if (rst) begin
      wr_l  <= 1'b0;
      rd_l  <= 1'b0;
      pop_d <= 1'b0;
    end else begin
      wr_l  <= main_wr;
      rd_l  <= snd_rd;
      pop_d <= pop;
    end
  end

`ifdef JTKUNIO_SNDFIFO_EN
  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic [7:0]    last;   // last popped command, shown while empty
  logic          push;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  // A pop on an empty FIFO is ignored. A push into a full FIFO is accepted
  // only when a pop frees a slot in the same cycle.
  assign pop     = pop_edge & ~empty;
  assign push    = push_edge & (~full | pop);
  assign ovf_set = push_edge & full & ~pop;

  // Command storage
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Entries are only visible once
    // written, and leaving them unreset keeps the array a plain RAM.
    if (push) mem[wr_ptr] <= main_din;
  end

  // Pointers, occupancy and last popped value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      last   <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign snd_dout = empty ? last : mem[rd_ptr];
  assign level    = cnt;
`else
  logic [7:0] data;
  logic       pend;

  assign pop     = pop_edge & pend;
  assign ovf_set = push_edge & pend;

  // Single latch. A push always overwrites it, and a same-cycle push keeps it pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= 8'h00;
      pend <= 1'b0;
    end else begin
      if (push_edge) data <= main_din;
      pend <= push_edge | (pend & ~pop);
    end
  end

  assign snd_dout = data;
  assign empty    = ~pend;
  assign full     = pend;
  assign level    = pend;
`endif

  // Sticky overflow. A set in the same cycle as ovf_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  assign snd_irq = ~empty & ~pop_d;

endmodule
